operand_fetch_unit: RTL

Parametrised operand-fetch stage between instruction fetch and execute. Decodes the opcode, reads two source operands from an internal register file, and tracks in-flight register writers with a per-register scoreboard. It stalls fetch on read-after-write hazards and presents one registered operand bundle per cycle to execute over a valid/ready handshake. Writeback, and kills of squashed instructions, return through a dedicated port.

---
 rtl/of_pkg.sv | 41 ++++
 rtl/operand_fetch_unit_if.sv | 58 +++++
 rtl/of_decode.sv | 46 ++++
 rtl/operand_fetch_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// Shared definitions for the operand fetch unit: opcodes, control-word
// field positions and the decoded-instruction record.
package of_pkg;

  // Opcode map. Anything not listed decodes as a bubble (no reads, no write).
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_SW  = 4'b0100;
  localparam logic [3:0] OP_BEQ = 4'b0101;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int CTRL_BITS = 10;

  // Control word bit positions.
  localparam int C_SUB     = 0;  // ALU subtracts
  localparam int C_MEM_RD  = 1;  // load
  localparam int C_MEM_WR  = 2;  // store
  localparam int C_BRANCH  = 3;  // compare-and-branch
  localparam int C_ALU     = 4;  // ALU result is the writeback value
  localparam int C_WB      = 5;  // instruction writes a register
  localparam int C_USE_RS1 = 6;  // first source operand is read
  localparam int C_USE_RS2 = 7;  // second source operand is read
  localparam int C_HINT_LO = 8;  // [9:8]: downstream stall hint
  localparam int C_HINT_HI = 9;

  // Stall hint values carried in ctrl[9:8].
  localparam logic [1:0] HINT_NONE   = 2'b00;
  localparam logic [1:0] HINT_BRANCH = 2'b01;
  localparam logic [1:0] HINT_LOAD   = 2'b10;

  // Decoder result. dest_sel=1 selects rd as destination, 0 selects rs1.
  typedef struct packed {
    logic [CTRL_BITS-1:0] ctrl;
    logic                 wr_en;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 dest_sel;
  } dec_t;

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Bus bundle for the operand fetch unit: fetch-side input handshake,
// execute-side output handshake, flush, writeback/kill return port, and a
// debug view of the per-register scoreboard counters.
// Handshake: a transfer happens on a posedge where valid and ready are both
// high; a valid bundle is held stable until it transfers (or is flushed).
interface operand_fetch_unit_if #(
  parameter int XLEN   = 64,
  parameter int NREG   = 16,
  parameter int PC_W   = 8,
  parameter int ADDR_W = 8,
  parameter int SB_W   = 2,
  parameter int CTRL_W = 10
);
  localparam int RA_W = $clog2(NREG);

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [3:0]        in_opcode;
  logic [RA_W-1:0]   in_rs1;
  logic [RA_W-1:0]   in_rs2;
  logic [RA_W-1:0]   in_rd;
  logic [ADDR_W-1:0] in_addr;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [PC_W-1:0]   out_pc;
  logic [ADDR_W-1:0] out_addr;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [RA_W-1:0]   out_rd;
  logic              out_wr_en;

  logic              flush;
  logic              wb_en;
  logic              wb_kill;
  logic [RA_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              stall;

  logic [NREG*SB_W-1:0] sb_cnt;

  modport master (
    output in_valid, in_pc, in_opcode, in_rs1, in_rs2, in_rd, in_addr,
    output out_ready, flush, wb_en, wb_kill, wb_rd, wb_data,
    input  in_ready, out_valid, out_ctrl, out_pc, out_addr,
    input  out_rs1_data, out_rs2_data, out_rd, out_wr_en, stall, sb_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_opcode, in_rs1, in_rs2, in_rd, in_addr,
    input  out_ready, flush, wb_en, wb_kill, wb_rd, wb_data,
    output in_ready, out_valid, out_ctrl, out_pc, out_addr,
    output out_rs1_data, out_rs2_data, out_rd, out_wr_en, stall, sb_cnt
  );

endinterface

// File: rtl/of_decode.sv
// Combinational opcode decoder: control word plus the read/write/destination
// flags the hazard logic needs.
module of_decode
  import of_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  // Build the control word, then derive the scoreboard flags from it.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        dec.ctrl[C_SUB]     = (opcode == OP_SUB);
        dec.ctrl[C_ALU]     = 1'b1;
        dec.ctrl[C_WB]      = 1'b1;
        dec.ctrl[C_USE_RS1] = 1'b1;
        dec.ctrl[C_USE_RS2] = 1'b1;
      end
      OP_LW: begin
        // Load form: absolute address field, result lands in rs1.
        dec.ctrl[C_MEM_RD]              = 1'b1;
        dec.ctrl[C_WB]                  = 1'b1;
        dec.ctrl[C_HINT_HI:C_HINT_LO]   = HINT_LOAD;
      end
      OP_SW: begin
        // Store data comes from rs1; address is the address field.
        dec.ctrl[C_MEM_WR]  = 1'b1;
        dec.ctrl[C_USE_RS1] = 1'b1;
      end
      OP_BEQ: begin
        dec.ctrl[C_BRANCH]            = 1'b1;
        dec.ctrl[C_USE_RS1]           = 1'b1;
        dec.ctrl[C_USE_RS2]           = 1'b1;
        dec.ctrl[C_HINT_HI:C_HINT_LO] = HINT_BRANCH;
      end
      default: dec.ctrl = '0;
    endcase
    dec.wr_en    = dec.ctrl[C_WB];
    dec.rs1_used = dec.ctrl[C_USE_RS1];
    dec.rs2_used = dec.ctrl[C_USE_RS2];
    dec.dest_sel = dec.ctrl[C_ALU];
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: decode, register-file read, per-register writer
// scoreboard with RAW/overflow stall, one-entry registered output bundle.
// Optional feature macro: OF_WB_BYPASS_EN forwards same-cycle writeback data
// to a waiting reader whose only outstanding writer is retiring.
module operand_fetch_unit
  import of_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREG   = 16,
  parameter int PC_W   = 8,
  parameter int ADDR_W = 8,
  parameter int SB_W   = 2,
  parameter int CTRL_W = 10
) (
  input logic clk,
  input logic rst,
  operand_fetch_unit_if.slave bus
);

  localparam int RA_W = $clog2(NREG);
  localparam logic [SB_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] regs [NREG];
  logic [SB_W-1:0] cnt  [NREG];

  dec_t            dec;
  logic [RA_W-1:0] dest;
  logic            byp1, byp2, hazard, ready, accept;
  logic            wb_ret, flush_ret;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            inc_hit  [NREG];
  logic [1:0]      ret_hits [NREG];

  logic              out_valid, out_wr_en;
  logic [CTRL_W-1:0] out_ctrl;
  logic [PC_W-1:0]   out_pc;
  logic [ADDR_W-1:0] out_addr;
  logic [XLEN-1:0]   out_rs1_data, out_rs2_data;
  logic [RA_W-1:0]   out_rd;

  of_decode u_decode (
    .opcode (bus.in_opcode),
    .dec    (dec)
  );

  // New count = old + increment - retirements, floored at zero.
  function automatic logic [SB_W-1:0] next_count(logic [SB_W-1:0] c, logic inc,
                                                 logic [1:0] nret);
    int up;
    int down;
    up   = int'(c) + int'(inc);
    down = int'(nret);
    return (up > down) ? SB_W'(up - down) : '0;
  endfunction

  // Operand select, hazard detection and intake handshake.
  always_comb begin
    dest = dec.dest_sel ? bus.in_rd : bus.in_rs1;
`ifdef OF_WB_BYPASS_EN
    byp1 = bus.wb_en && (bus.wb_rd == bus.in_rs1) && (cnt[bus.in_rs1] == SB_W'(1));
    byp2 = bus.wb_en && (bus.wb_rd == bus.in_rs2) && (cnt[bus.in_rs2] == SB_W'(1));
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    rs1_data = byp1 ? bus.wb_data : regs[bus.in_rs1];
    rs2_data = byp2 ? bus.wb_data : regs[bus.in_rs2];
    hazard   = (dec.rs1_used && (cnt[bus.in_rs1] != '0) && !byp1) ||
               (dec.rs2_used && (cnt[bus.in_rs2] != '0) && !byp2) ||
               (dec.wr_en && (cnt[dest] == CNT_MAX));
    ready    = !rst && !bus.flush && !hazard && (!out_valid || bus.out_ready);
    accept   = bus.in_valid && ready;
    wb_ret    = bus.wb_en || bus.wb_kill;
    flush_ret = bus.flush && out_valid && out_wr_en;
  end

  // Per-register increment/retire events for this cycle.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_hit[r]  = accept && dec.wr_en && (dest == RA_W'(r));
      ret_hits[r] = {1'b0, wb_ret && (bus.wb_rd == RA_W'(r))} +
                    {1'b0, flush_ret && (out_rd == RA_W'(r))};
    end
  end

  // Scoreboard counters; reset discards all in-flight writer state.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst) cnt[r] <= '0;
      else     cnt[r] <= next_count(cnt[r], inc_hit[r], ret_hits[r]);
    end
  end

  // Register file write port; writeback is ignored while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (bus.wb_en) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Output bundle register: load on accept, drop on flush or hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_ctrl     <= '0;
      out_pc       <= '0;
      out_addr     <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_wr_en    <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_ctrl     <= CTRL_W'(dec.ctrl);
      out_pc       <= bus.in_pc;
      out_addr     <= bus.in_addr;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_rd       <= dest;
      out_wr_en    <= dec.wr_en;
    end else if (bus.flush || bus.out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Flatten the scoreboard for the debug view.
  always_comb begin
    bus.sb_cnt = '0;
    for (int r = 0; r < NREG; r++) bus.sb_cnt[r*SB_W +: SB_W] = cnt[r];
  end

  assign bus.in_ready     = ready;
  assign bus.stall        = !rst && bus.in_valid && hazard;
  assign bus.out_valid    = out_valid;
  assign bus.out_ctrl     = out_ctrl;
  assign bus.out_pc       = out_pc;
  assign bus.out_addr     = out_addr;
  assign bus.out_rs1_data = out_rs1_data;
  assign bus.out_rs2_data = out_rs2_data;
  assign bus.out_rd       = out_rd;
  assign bus.out_wr_en    = out_wr_en;

endmodule
